// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the K=3, rate-1/2 (7,5) Viterbi path-metric datapath.
package viterbi_pkg;
   localparam int NUM_STATES = 4;
   localparam int BM_W       = 2;

   typedef logic [1:0] state_t;
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

   // New state n={u,b1} is reached from {b1,0} (even) and {b1,1} (odd);
   // the BM index is the code word emitted on that branch.
   localparam state_t     PRED_EVEN [NUM_STATES] = '{2'd0, 2'd2, 2'd0, 2'd2};
   localparam state_t     PRED_ODD  [NUM_STATES] = '{2'd1, 2'd3, 2'd1, 2'd3};
   localparam logic [1:0] BM_EVEN   [NUM_STATES] = '{2'd0, 2'd2, 2'd3, 2'd1};
   localparam logic [1:0] BM_ODD    [NUM_STATES] = '{2'd3, 2'd1, 2'd0, 2'd2};
endpackage

// File: rtl/acs_cell.sv
// Two-candidate add-compare-select; a tie keeps the even predecessor.
module acs_cell
   import viterbi_pkg::*;
#(
   parameter int PM_W = 6
) (
   input  logic [PM_W-1:0] pm_even,
   input  logic [PM_W-1:0] pm_odd,
   input  logic [BM_W-1:0] bm_even,
   input  logic [BM_W-1:0] bm_odd,
   output logic [PM_W:0]   metric,
   output logic            decision
);
   logic [PM_W:0] sum_even, sum_odd;

   assign sum_even = {1'b0, pm_even} + (PM_W+1)'(bm_even);
   assign sum_odd  = {1'b0, pm_odd}  + (PM_W+1)'(bm_odd);
   assign decision = (sum_odd < sum_even);
   assign metric   = decision ? sum_odd : sum_even;
endmodule

// File: rtl/acs_path_metric_unit.sv
// Four-state ACS stage with min-normalisation, saturation and per-frame sequencing.
module acs_path_metric_unit
   import viterbi_pkg::*;
#(
   parameter int PM_W      = 6,
   parameter int PM_INIT   = 8,
   parameter int FRAME_LEN = 64
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic            i_valid,
   input  logic [BM_W-1:0] i_BM_0,
   input  logic [BM_W-1:0] i_BM_1,
   input  logic [BM_W-1:0] i_BM_2,
   input  logic [BM_W-1:0] i_BM_3,
   output logic            o_valid,
   output logic            o_last,
   output logic [3:0]      o_decision,
   output state_t          o_best_state,
   output logic [PM_W-1:0] o_PM_0,
   output logic [PM_W-1:0] o_PM_1,
   output logic [PM_W-1:0] o_PM_2,
   output logic [PM_W-1:0] o_PM_3
);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN);
   localparam logic [NUM_STATES-1:0][PM_W-1:0] PM_RESET =
      {PM_W'(PM_INIT), PM_W'(PM_INIT), PM_W'(PM_INIT), PM_W'(0)};

   fsm_t                              fsm_q, fsm_d;
   logic [CW-1:0]                     cnt_q, cnt_src, cnt_inc;
   logic [NUM_STATES-1:0][PM_W-1:0]   pm_q, pm_src, pm_norm;
   logic [NUM_STATES-1:0][BM_W-1:0]   bm;
   logic [NUM_STATES-1:0][PM_W:0]     sums, diff;
   logic [NUM_STATES-1:0]             dec;
   logic [PM_W:0]                     min_m;
   state_t                            best;
   logic                              accept, last;

   assign bm      = {i_BM_3, i_BM_2, i_BM_1, i_BM_0};
   // A start in the same cycle as a valid symbol runs ACS on the init metrics.
   assign pm_src  = i_start ? PM_RESET : pm_q;
   assign cnt_src = i_start ? '0 : cnt_q;
   assign cnt_inc = cnt_src + CW'(1);
   assign accept  = i_valid && (i_start || fsm_q == RUN);
   assign last    = accept && (cnt_inc == LAST_CNT);

   for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
      acs_cell #(.PM_W(PM_W)) u_acs (
         .pm_even  (pm_src[PRED_EVEN[n]]),
         .pm_odd   (pm_src[PRED_ODD[n]]),
         .bm_even  (bm[BM_EVEN[n]]),
         .bm_odd   (bm[BM_ODD[n]]),
         .metric   (sums[n]),
         .decision (dec[n])
      );
   end

   always_comb begin
      min_m = sums[0];
      for (int i = 1; i < NUM_STATES; i++)
         if (sums[i] < min_m) min_m = sums[i];
      best = '0;
      for (int i = 0; i < NUM_STATES; i++) begin
         diff[i]    = sums[i] - min_m;
         pm_norm[i] = diff[i][PM_W] ? '1 : diff[i][PM_W-1:0];
      end
      // Descending scan so the lowest-index minimum wins.
      for (int i = NUM_STATES-1; i >= 0; i--)
         if (sums[i] == min_m) best = state_t'(i);
   end

   always_comb begin
      fsm_d = fsm_q;
      if (last)         fsm_d = IDLE;
      else if (i_start) fsm_d = RUN;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fsm_q        <= IDLE;
         cnt_q        <= '0;
         pm_q         <= PM_RESET;
         o_valid      <= 1'b0;
         o_last       <= 1'b0;
         o_decision   <= '0;
         o_best_state <= '0;
      end else begin
         fsm_q   <= fsm_d;
         o_valid <= accept;
         o_last  <= last;
         if (accept) begin
            pm_q         <= pm_norm;
            o_decision   <= dec;
            o_best_state <= best;
            cnt_q        <= last ? '0 : cnt_inc;
         end else if (i_start) begin
            pm_q  <= PM_RESET;
            cnt_q <= '0;
         end
      end
   end

   assign o_PM_0 = pm_q[0];
   assign o_PM_1 = pm_q[1];
   assign o_PM_2 = pm_q[2];
   assign o_PM_3 = pm_q[3];
endmodule

// File: tb/tb_acs_path_metric_unit.sv
// Random and directed stimulus against a trellis-level model of the ACS unit.
module tb_acs_path_metric_unit;
   localparam int PM_W = 6, PM_INIT = 8, FL = 4, PM_MAX = 63;

   logic       i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_valid = 1'b0;
   logic [1:0] i_BM_0 = '0, i_BM_1 = '0, i_BM_2 = '0, i_BM_3 = '0;
   logic       o_valid, o_last;
   logic [3:0] o_decision;
   logic [1:0] o_best_state;
   logic [PM_W-1:0] o_PM_0, o_PM_1, o_PM_2, o_PM_3;

   int vecs = 0, errs = 0;

   acs_path_metric_unit #(.PM_W(PM_W), .PM_INIT(PM_INIT), .FRAME_LEN(FL)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid),
      .i_BM_0(i_BM_0), .i_BM_1(i_BM_1), .i_BM_2(i_BM_2), .i_BM_3(i_BM_3),
      .o_valid(o_valid), .o_last(o_last), .o_decision(o_decision),
      .o_best_state(o_best_state),
      .o_PM_0(o_PM_0), .o_PM_1(o_PM_1), .o_PM_2(o_PM_2), .o_PM_3(o_PM_3)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: walk every trellis branch of the (7,5) code.
   int   m_pm[4], m_cnt, m_best, base[4], nm[4], bmv[4], mn, cnt0, cand, v;
   int   nx, b1, b0, c0, c1;
   bit   m_run, m_valid, m_last;
   logic [3:0] m_dec, d;

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_pm = '{0, PM_INIT, PM_INIT, PM_INIT};
         m_cnt = 0; m_run = 0; m_valid = 0; m_last = 0; m_dec = '0; m_best = 0;
      end else if (i_valid && (i_start || m_run)) begin
         bmv  = '{int'(i_BM_0), int'(i_BM_1), int'(i_BM_2), int'(i_BM_3)};
         base = i_start ? '{0, PM_INIT, PM_INIT, PM_INIT} : m_pm;
         cnt0 = i_start ? 0 : m_cnt;
         nm   = '{1 << 30, 1 << 30, 1 << 30, 1 << 30};
         d    = '0;
         for (int s = 0; s < 4; s++)
            for (int u = 0; u < 2; u++) begin
               b1 = (s >> 1) & 1; b0 = s & 1;
               nx = u * 2 + b1;
               c0 = u ^ b1 ^ b0; c1 = u ^ b0;
               cand = base[s] + bmv[c0 * 2 + c1];
               if (cand < nm[nx]) begin nm[nx] = cand; d[nx] = b0[0]; end
            end
         mn = nm[0];
         for (int n = 1; n < 4; n++) if (nm[n] < mn) mn = nm[n];
         m_best = -1;
         for (int n = 0; n < 4; n++) begin
            v = nm[n] - mn;
            if (v > PM_MAX) v = PM_MAX;
            m_pm[n] = v;
            if (v == 0 && m_best < 0) m_best = n;
         end
         m_dec = d; m_valid = 1;
         cnt0++;
         if (cnt0 == FL) begin m_last = 1; m_cnt = 0; m_run = 0; end
         else begin m_last = 0; m_cnt = cnt0; m_run = 1; end
      end else begin
         m_valid = 0; m_last = 0;
         if (i_start) begin
            m_pm = '{0, PM_INIT, PM_INIT, PM_INIT}; m_cnt = 0; m_run = 1;
         end
      end
   end

   always @(negedge i_clk) begin
      if (!i_rst) begin
         chk("valid", o_valid, m_valid);
         chk("last", o_last, m_last);
         chk("decision", o_decision, m_dec);
         chk("best_state", o_best_state, m_best);
         chk("pm0", o_PM_0, m_pm[0]);
         chk("pm1", o_PM_1, m_pm[1]);
         chk("pm2", o_PM_2, m_pm[2]);
         chk("pm3", o_PM_3, m_pm[3]);
      end
   end

   // Drive one cycle; BMs are Hamming distances of the received code to 00/01/10/11.
   task automatic cyc(input bit st, input bit vl, input logic [1:0] code);
      logic [1:0] x0, x1, x2, x3;
      x0 = code ^ 2'b00; x1 = code ^ 2'b01; x2 = code ^ 2'b10; x3 = code ^ 2'b11;
      i_start = st; i_valid = vl;
      i_BM_0 = 2'(x0[0] + x0[1]); i_BM_1 = 2'(x1[0] + x1[1]);
      i_BM_2 = 2'(x2[0] + x2[1]); i_BM_3 = 2'(x3[0] + x3[1]);
      @(negedge i_clk);
   endtask

   task automatic pm4(input string nm, input int a, input int b, input int c, input int e);
      chk({nm, "_pm0"}, o_PM_0, a); chk({nm, "_pm1"}, o_PM_1, b);
      chk({nm, "_pm2"}, o_PM_2, c); chk({nm, "_pm3"}, o_PM_3, e);
   endtask

   task automatic rst_vals(input string nm);
      chk({nm, "_valid"}, o_valid, 0); chk({nm, "_last"}, o_last, 0);
      chk({nm, "_dec"}, o_decision, 0); chk({nm, "_best"}, o_best_state, 0);
      pm4(nm, 0, PM_INIT, PM_INIT, PM_INIT);
   endtask

   initial begin
      @(negedge i_clk); @(negedge i_clk);
      rst_vals("reset");
      i_rst = 1'b0;
      cyc(0, 1, 2'b00);  chk("idle_ignore_valid", o_valid, 0);
      cyc(1, 0, 2'b00);  chk("start_only_valid", o_valid, 0);
      pm4("start_only", 0, 8, 8, 8);
      cyc(0, 1, 2'b00);
      chk("sym00_valid", o_valid, 1);
      pm4("sym00", 0, 9, 2, 9);
      chk("sym00_dec", o_decision, 4'b0000);
      chk("tie_bit1", o_decision[1], 0); chk("tie_bit3", o_decision[3], 0);
      chk("sym00_best", o_best_state, 0);
      cyc(0, 0, 2'b00);  chk("gap_valid", o_valid, 0); pm4("gap_hold", 0, 9, 2, 9);
      cyc(1, 1, 2'b11);  pm4("s11", 2, 9, 0, 9);
      cyc(0, 1, 2'b10);  pm4("s10", 3, 0, 3, 2);
      cyc(0, 1, 2'b11);  pm4("s11b", 0, 3, 2, 3);
      chk("s11b_dec", o_decision, 4'b1111); chk("s11b_best", o_best_state, 0);
      chk("s11b_last", o_last, 0);
      cyc(0, 0, 2'b00);
      cyc(0, 1, 2'b01);  chk("frame_last", o_last, 1); chk("frame_last_valid", o_valid, 1);
      cyc(0, 1, 2'b01);  chk("post_frame_valid", o_valid, 0);
      // restart after two symbols
      cyc(1, 1, 2'b00);
      cyc(0, 1, 2'b01);
      cyc(1, 0, 2'b00);  pm4("reload", 0, 8, 8, 8); chk("reload_valid", o_valid, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(0, 1, 2'(k));
         chk("restart_last", o_last, k == 4);
         cyc(0, 0, 2'b00);
      end
      // asynchronous reset mid-frame
      cyc(1, 1, 2'b10);
      cyc(0, 1, 2'b11);
      #2 i_rst = 1'b1;
      #1 rst_vals("async_rst");
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      cyc(0, 1, 2'b00);  chk("after_rst_valid", o_valid, 0);
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            #2 i_rst = 1'b1;
            #1 i_rst = 1'b0;
         end
         cyc($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)));
      end
      i_start = 0; i_valid = 0;
      @(negedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/acs_path_metric_unit.md
ACS_PATH_METRIC_UNIT -- requirements
Module: acs_path_metric_unit

Interface
REQ-001 SHALL have parameter PM_W, default 6, path-metric width in bits.
REQ-002 SHALL have parameter PM_INIT, default 8, reset/start metric for states 1..3.
REQ-003 SHALL have parameter FRAME_LEN, default 64, symbols per frame.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 i_clk  in  1  rising-edge clock.
REQ-006 i_rst  in  1  asynchronous active-high reset.
REQ-007 i_start  in  1  frame start; reinitialise metrics and symbol counter.
REQ-008 i_valid  in  1  branch metrics valid this cycle.
REQ-009 i_BM_0..i_BM_3  in  2 each  Hamming distance of received symbol to codes 00/01/10/11.
REQ-010 o_valid  out  1  decision/metric outputs updated this cycle.
REQ-011 o_last  out  1  qualifies o_valid for the FRAME_LEN-th symbol.
REQ-012 o_decision  out  4  survivor bit per new state n (bit n).
REQ-013 o_best_state  out  2  index of minimum updated metric.
REQ-014 o_PM_0..o_PM_3  out  PM_W each  registered path metrics.

Function
REQ-015 Trellis SHALL be K=3, rate 1/2, generators 7,5 octal; state {b1,b0}, next state {u,b1}.
REQ-016 Candidates SHALL be: new0 = PM0+BM0 vs PM1+BM3; new2 = PM0+BM3 vs PM1+BM0; new1 = PM2+BM2 vs PM3+BM1; new3 = PM2+BM1 vs PM3+BM2.
REQ-017 Each new state SHALL take the smaller candidate; decision bit 1 when the odd predecessor wins; a tie SHALL select the even predecessor (bit 0).
REQ-018 Candidates SHALL be computed in PM_W+1 bits; the minimum of the four selected metrics SHALL be subtracted from each, and results above 2^PM_W-1 SHALL saturate there.
REQ-019 o_best_state SHALL be the state whose normalised metric is 0; on ties, the lowest index.
REQ-020 FSM SHALL have states IDLE and RUN; reset enters IDLE.
REQ-021 IDLE: i_valid ignored without i_start; o_valid stays 0; i_start moves to RUN.
REQ-022 i_start (either state) SHALL load PM0=0, PM1..3=PM_INIT and clear the symbol counter.
REQ-023 i_start with i_valid in the same cycle SHALL process that symbol as symbol 1 of the new frame, using the init metrics.
REQ-024 RUN: each i_valid cycle SHALL register ACS results; o_valid SHALL pulse one cycle later (latency 1); the counter increments.
REQ-025 RUN: i_valid low SHALL hold metrics and counter; o_valid SHALL be 0.
REQ-026 On the FRAME_LEN-th valid symbol, o_last SHALL assert with o_valid; the counter wraps to 0; FSM returns to IDLE.
REQ-027 o_decision, o_best_state and o_PM_* SHALL hold their last values while o_valid is 0.

Reset
REQ-028 i_rst SHALL asynchronously force IDLE, counter 0, o_valid=0, o_last=0, o_decision=0, o_best_state=0, o_PM_0=0, o_PM_1..3=PM_INIT.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, no o_valid until i_start.

Structure
REQ-030 viterbi_pkg SHALL hold NUM_STATES=4, BM_W=2, the 2-bit state typedef, and predecessor/BM-index tables.
REQ-031 One sub-module, acs_cell, SHALL implement two-candidate add-compare-select with decision output; four instances.
REQ-032 Normalisation, FSM, counter and registers SHALL reside in the top module.

Verification
REQ-033 Reset, i_start, symbol 00 (BM 0,1,1,2) -> o_PM={0,9,2,9}, o_decision=0000, o_best_state=0, o_valid one cycle later.
REQ-034 i_start with i_valid, symbols 11,10,11 -> PM {2,9,0,9}, {3,0,3,2}, {0,3,2,3}; final o_decision=1111, o_best_state=0.
REQ-035 Tie check: first symbol 00 -> new1 and new3 tie at 9 -> decision bits 1 and 3 = 0.
REQ-036 FRAME_LEN=4, four valid symbols with gaps -> o_last only with the 4th o_valid; FSM returns to IDLE; further i_valid produces no o_valid.
REQ-037 i_start mid-frame after 2 symbols -> metrics reload to {0,8,8,8}; o_last only after 4 more symbols.
REQ-038 i_rst pulse mid-frame -> outputs reach REQ-028 values immediately, before any clock edge.
